// File: rtl/tiny16_mem_arb.sv
// Single-port memory arbiter for tiny16: loader, load/store and fetch share one
// synchronous 16-bit memory. Define TINY16_ARB_RR_EN for round-robin between load/store and fetch.
module tiny16_mem_arb #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [15:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  input  logic              ld_req,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_wdata,
  output logic              ld_gnt,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_LS   = 2'd2
  } tag_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              locked_q, locked_d;
  tag_e              tag_q, tag_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              lock_active;
  logic              fetch_starved;

  // A lock only holds off other requesters while the loader keeps ld_lock high.
  assign lock_active   = locked_q && ld_lock;
  assign fetch_starved = if_req && (starve_q >= STARVE_LIM);

`ifdef TINY16_ARB_RR_EN
  logic rr_last_if_q, rr_last_if_d;
`endif

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (RST) begin
      if_gnt = 1'b0;
    end else if (lock_active) begin
      ld_gnt = ld_req;
    end else if (fetch_starved) begin
      if_gnt = 1'b1;
    end else if (ld_req) begin
      ld_gnt = 1'b1;
`ifdef TINY16_ARB_RR_EN
    end else if (ls_req && if_req) begin
      ls_gnt = rr_last_if_q;
      if_gnt = !rr_last_if_q;
`endif
    end else if (ls_req) begin
      ls_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

  // Memory command follows the winner; address and write data hold when idle.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (ld_gnt) begin
      mem_addr_d  = ld_addr;
      mem_wdata_d = ld_wdata;
    end else if (ls_gnt) begin
      mem_addr_d  = ls_addr;
      mem_wdata_d = ls_wdata;
    end else if (if_gnt) begin
      mem_addr_d  = if_addr;
    end
  end

  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign mem_we    = ld_gnt || (ls_gnt && ls_we);

  always_comb begin
    starve_d = 4'd0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end

    locked_d = locked_q;
    if (!ld_lock) begin
      locked_d = 1'b0;
    end else if (ld_gnt) begin
      locked_d = 1'b1;
    end

    tag_d = TAG_NONE;
    if (if_gnt) begin
      tag_d = TAG_IF;
    end else if (ls_gnt && !ls_we) begin
      tag_d = TAG_LS;
    end
  end

`ifdef TINY16_ARB_RR_EN
  always_comb begin
    rr_last_if_d = rr_last_if_q;
    if (if_gnt) begin
      rr_last_if_d = 1'b1;
    end else if (ls_gnt) begin
      rr_last_if_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_last_if_q <= 1'b1;
    end else begin
      rr_last_if_q <= rr_last_if_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q    <= 4'd0;
      locked_q    <= 1'b0;
      tag_q       <= TAG_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      locked_q    <= locked_d;
      tag_q       <= tag_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Gating with RST drops the return of a read caught by a mid-run reset.
  assign if_rvalid = !RST && (tag_q == TAG_IF);
  assign ls_rvalid = !RST && (tag_q == TAG_LS);
  assign rdata     = (!RST && (tag_q != TAG_NONE)) ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_tiny16_mem_arb.sv
// Directed testbench for tiny16_mem_arb with a synchronous memory model.
module tb_tiny16_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we, ld_req, ld_lock;
  logic [7:0]  if_addr, ls_addr, ld_addr;
  logic [15:0] ls_wdata, ld_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ld_gnt;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  tiny16_mem_arb #(.ADDR_W(8), .STARVE_MAX(4)) dut (
    .CLK(clk), .RST(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ld_req(ld_req), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ld_req = 1'b1; ld_lock = 1'b0; ld_addr = 8'h40; ld_wdata = 16'h5555;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h41; ls_wdata = 16'h0000;
    if_req = 1'b1; if_addr = 8'h05;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ld_gnt, ls_gnt, if_gnt, ls_rvalid, if_rvalid, mem_we} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_ctl[%0d]: got %b want 000000", c,
                 {ld_gnt, ls_gnt, if_gnt, ls_rvalid, if_rvalid, mem_we});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata, rdata} !== 40'h0) begin
        n_err++;
        $display("FAIL reset_data[%0d]: got %h/%h/%h want 00/0000/0000", c, mem_addr, mem_wdata, rdata);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_first_gnt: got %b want 100", {ld_gnt, ls_gnt, if_gnt});
    end
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h40, 16'h5555}) begin
      n_err++;
      $display("FAIL reset_first_cmd: got %b/%h/%h want 1/40/5555", mem_we, mem_addr, mem_wdata);
    end
    tick();
    idle();
  endtask

  task automatic test_solo_fetch();
    if_req = 1'b1; if_addr = 8'h05;
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt, mem_we, mem_addr} !== {4'b0010, 8'h05}) begin
      n_err++;
      $display("FAIL solo_gnt: got %b/%b/%h want 001/0/05", {ld_gnt, ls_gnt, if_gnt}, mem_we, mem_addr);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, ls_rvalid, rdata} !== {2'b10, 16'h1234}) begin
      n_err++;
      $display("FAIL solo_rdata: got %b%b/%h want 10/1234", if_rvalid, ls_rvalid, rdata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, mem_we, mem_addr} !== {2'b00, 8'h05}) begin
      n_err++;
      $display("FAIL solo_idle_hold: got %b/%b/%h want 0/0/05", if_rvalid, mem_we, mem_addr);
    end
    idle();
  endtask

  task automatic test_reset_midop();
    if_req = 1'b1; if_addr = 8'h05;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_gnt: got %b want 1", if_gnt);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt, if_rvalid, ls_rvalid, rdata} !== 21'h0) begin
      n_err++;
      $display("FAIL midrst_suppress: got %b%b%b/%b%b/%h want 000/00/0000",
               ld_gnt, ls_gnt, if_gnt, if_rvalid, ls_rvalid, rdata);
    end
    tick();
    rst = 1'b0; if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_after: got %b%b want 00", if_rvalid, ls_rvalid);
    end
    idle();
  endtask

  task automatic test_starvation();
    ld_req = 1'b1; ld_lock = 1'b0; ld_addr = 8'h30; ld_wdata = 16'h7777;
    if_req = 1'b1; if_addr = 8'h05;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ld_gnt, ls_gnt, if_gnt} !== 3'b100) begin
        n_err++;
        $display("FAIL starve_ld[%0d]: got %b want 100", c, {ld_gnt, ls_gnt, if_gnt});
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt, mem_addr} !== {3'b001, 8'h05}) begin
      n_err++;
      $display("FAIL starve_if: got %b/%h want 001/05", {ld_gnt, ls_gnt, if_gnt}, mem_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt} !== 3'b100) begin
      n_err++;
      $display("FAIL starve_cleared: got %b want 100", {ld_gnt, ls_gnt, if_gnt});
    end
    n_cmp++;
    if ({if_rvalid, rdata} !== {1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL starve_rdata: got %b/%h want 1/1234", if_rvalid, rdata);
    end
    idle();
  endtask

  task automatic test_lock();
    ld_req = 1'b1; ld_lock = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h00;
    if_req = 1'b1; if_addr = 8'h01;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 8'(i); ld_wdata = 16'hAA00 + 16'(i);
      @(negedge clk);
      n_cmp++;
      if ({ld_gnt, ls_gnt, if_gnt, mem_we, mem_addr, mem_wdata} !== {4'b1001, 8'(i), 16'hAA00 + 16'(i)}) begin
        n_err++;
        $display("FAIL lock_wr[%0d]: got %b/%b/%h/%h", i, {ld_gnt, ls_gnt, if_gnt}, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    ld_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt, mem_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL lock_gap: got %b/%b want 000/0", {ld_gnt, ls_gnt, if_gnt}, mem_we);
    end
    tick();
    ld_lock = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ld_gnt, ls_gnt, if_gnt} !== 3'b001) begin
      n_err++;
      $display("FAIL lock_release: got %b want 001", {ld_gnt, ls_gnt, if_gnt});
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ls_gnt, if_rvalid, rdata} !== {2'b11, 16'hAA01}) begin
      n_err++;
      $display("FAIL lock_rd1: got %b%b/%h want 11/aa01", ls_gnt, if_rvalid, rdata);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      if (i == 4) ls_req = 1'b0;
      else ls_addr = 8'(i);
      @(negedge clk);
      n_cmp++;
      if ({ls_rvalid, if_rvalid, rdata} !== {2'b10, (i == 2) ? 16'hAA00 : 16'hAA00 + 16'(i - 1)}) begin
        n_err++;
        $display("FAIL lock_rd_ls[%0d]: got %b%b/%h", i, ls_rvalid, if_rvalid, rdata);
      end
    end
    idle();
  endtask

  task automatic test_mixed();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h10; ls_wdata = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if ({ls_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h10, 16'hBEEF}) begin
      n_err++;
      $display("FAIL mixed_wr: got %b%b/%h/%h want 11/10/beef", ls_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt, mem_we, ls_rvalid, if_rvalid} !== 4'b1000) begin
      n_err++;
      $display("FAIL mixed_rd_gnt: got %b%b%b%b want 1000", if_gnt, mem_we, ls_rvalid, if_rvalid);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, ls_rvalid, rdata} !== {2'b10, 16'hBEEF}) begin
      n_err++;
      $display("FAIL mixed_rdata: got %b%b/%h want 10/beef", if_rvalid, ls_rvalid, rdata);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_gnt [5];
`ifdef TINY16_ARB_RR_EN
    exp_gnt = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`else
    exp_gnt = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
`endif
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h40;
    if_req = 1'b1; if_addr = 8'h05;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) begin
        ls_req = 1'b0; if_req = 1'b0;
      end
      @(negedge clk);
      if (c < 5) begin
        n_cmp++;
        if ({ld_gnt, ls_gnt, if_gnt} !== exp_gnt[c]) begin
          n_err++;
          $display("FAIL b2b_gnt[%0d]: got %b want %b", c, {ld_gnt, ls_gnt, if_gnt}, exp_gnt[c]);
        end
      end
      if (c > 0) begin
        n_cmp++;
        if ({ls_rvalid, if_rvalid, rdata} !==
            {exp_gnt[c-1][1:0], exp_gnt[c-1][1] ? 16'h5555 : 16'h1234}) begin
          n_err++;
          $display("FAIL b2b_ret[%0d]: got %b%b/%h", c, ls_rvalid, if_rvalid, rdata);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[5] = 16'h1234;
    test_reset();
    test_solo_fetch();
    test_reset_midop();
    test_starvation();
    test_lock();
    test_mixed();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tiny16_mem_arb.md
# tiny16_mem_arb

Single-port memory arbiter for the tiny16 core. Shares the one 16-bit-wide synchronous memory between three requesters: the instruction fetch unit, the load/store unit, and the program loader that fills memory from the byte-wide `IN` path before and during execution. It issues one grant per cycle, returns read data one cycle after grant, and guarantees fetch forward progress with a starvation counter.

## Interface
- `ADDR_W`, 8: memory word-address width.
- `STARVE_MAX`, 4: consecutive denied cycles after which fetch is forced to win; legal range 1–15.
- `CLK` in 1: system clock, all logic on rising edge.
- `RST` in 1: reset; **one clock; reset is synchronous and active-high**.
- `if_req` in 1: fetch request, read only; held with `if_addr` stable until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch granted this cycle.
- `if_rvalid` out 1: `rdata` holds fetch data.
- `ls_req`, `ls_we` in 1: load/store request and write enable.
- `ls_addr` in ADDR_W, `ls_wdata` in 16: load/store address and write data.
- `ls_gnt`, `ls_rvalid` out 1: load/store grant and read-data valid; no rvalid for writes.
- `ld_req` in 1: loader write request, write only.
- `ld_lock` in 1: loader burst lock.
- `ld_addr` in ADDR_W, `ld_wdata` in 16: loader address and data.
- `ld_gnt` out 1: loader granted.
- `rdata` out 16: shared read-data return bus.
- `mem_addr` out ADDR_W, `mem_we` out 1, `mem_wdata` out 16: memory command.
- `mem_rdata` in 16: memory read data, valid the cycle after the address.

## Operation
- Each cycle, at most one `*_gnt` is high. A grant is combinational from the current `*_req` and the registered arbitration state. `mem_addr`, `mem_we` and `mem_wdata` carry the granted requester's fields that same cycle.
- With no grant: `mem_we` = 0, and `mem_addr`/`mem_wdata` hold their last value.
- Default priority: loader > load/store > fetch.
- Starvation counter `starve` is 4 bits:
  - increments each cycle `if_req`=1 and `if_gnt`=0, saturating at 15;
  - clears when `if_gnt`=1 or `if_req`=0.
  - When `starve` ≥ STARVE_MAX, fetch outranks everything except a locked loader.
- Loader lock:
  - `ld_gnt`=1 with `ld_lock`=1 sets `locked`.
  - While `locked`, only the loader may be granted. If `ld_req`=0 in a locked cycle, no one is granted.
  - `locked` clears on the first cycle with `ld_lock`=0.
- Read return:
  - A registered tag records the owner of a granted read, or none for writes.
  - Next cycle, `rdata` = `mem_rdata` and exactly that owner's `*_rvalid` pulses for one cycle.
  - Back-to-back grants pipeline fully: one read per cycle.
- Simultaneous write and read of the same address in consecutive cycles: memory ordering applies. The later read returns the written data.

## Timing
- Reset values:
  - all `*_gnt`, `*_rvalid` and `mem_we` = 0;
  - `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0;
  - `starve` = 0, `locked` = 0, return tag = none;
  - round-robin pointer = fetch.
- Reset mid-operation: an in-flight read's `rvalid` is suppressed. There is no grant in any cycle `RST`=1.
- Latency:
  - grant in the same cycle as `req` when uncontended;
  - read data at grant+1;
  - write committed at the grant edge.
- Handshake: the requester drops or changes `req`/fields only after seeing `gnt` high at a rising edge. Deasserting `req` without a grant is legal and discards the request.
- Worst-case fetch wait, unlocked: STARVE_MAX cycles.

## Configuration
- `TINY16_ARB_RR_EN` defined:
  - load/store and fetch rotate by round-robin; the last granted of the two loses a tie;
  - loader remains top priority;
  - starvation override still active.
- Undefined: fixed priority as above; the round-robin pointer is not implemented.

## Test plan
- Reset: hold `RST` 2 cycles with all reqs high → all grants/rvalid 0, `mem_we`=0. First grant after release goes to loader.
- Solo fetch: `if_req`, `if_addr`=0x05, memory[5]=0x1234 → `if_gnt` same cycle; next cycle `if_rvalid`=1, `rdata`=0x1234.
- Starvation, STARVE_MAX=4: `ls_req` held continuously with `if_req` → `ls` wins 4 cycles, then `if_gnt` on cycle 5, `starve` back to 0.
- Loader lock: `ld_lock`=1 and `ld_req` writing 0xAA00–0xAA03 to addr 0–3, with `ls_req`/`if_req` pending → no ls/if grant until `ld_lock`=0; subsequent reads of 0–3 return the written data.
- Pipelined mixed traffic: ls write 0xBEEF @0x10, then fetch read @0x10 next cycle → `if_rvalid` with `rdata`=0xBEEF; no `ls_rvalid` for the write.
- `TINY16_ARB_RR_EN`: continuous `ls_req` and `if_req` → grants alternate ls, if, ls, if; without the macro → ls every cycle until the starvation override.
